// File: rtl/pmu_pkg.sv
// Shared types and header layout helpers for the programming management unit.
package pmu_pkg;

    typedef enum logic [2:0] {StIdle, StHdr, StData, StChk, StDone, StErr} state_e;

    localparam int unsigned CntOff = 0;

    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int unsigned len_off(input int unsigned cnt_w);
        return cnt_w;
    endfunction

    function automatic int unsigned ch_off(input int unsigned cnt_w, input int unsigned len_w);
        return cnt_w + len_w;
    endfunction

endpackage

// File: rtl/crc_serial.sv
// Serial CRC engine, MSB feedback; a frame followed by its check bits leaves residue zero.
module crc_serial #(
    parameter int unsigned      CRC_W    = 8,
    parameter logic [CRC_W-1:0] CRC_POLY = 8'hEB
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    input  logic bit_i,
    output logic residue_zero_o
);

    logic [CRC_W-1:0] crc_q, crc_d, base;
    logic             fb;

    always_comb begin
        base  = clr_i ? '0 : crc_q;
        fb    = bit_i ^ base[CRC_W-1];
        crc_d = en_i ? ((base << 1) ^ (fb ? CRC_POLY : '0)) : crc_q;
    end

    // Residue after absorbing the current bit, so the FSM can decide on that same edge.
    assign residue_zero_o = (crc_d == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) crc_q <= '0;
        else         crc_q <= crc_d;
    end

endmodule

// File: rtl/pmu_stream_ctrl.sv
// Header parser and frame streamer feeding one of NUM_CH configuration chains.
module pmu_stream_ctrl
    import pmu_pkg::*;
#(
    parameter int unsigned      FRAME_W  = 64,
    parameter int unsigned      CRC_W    = 8,
    parameter logic [CRC_W-1:0] CRC_POLY = 8'hEB,
    parameter int unsigned      NUM_CH   = 2,
    parameter int unsigned      CNT_W    = 16,
    parameter int unsigned      LEN_W    = 7
) (
    input  logic              tck_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              crc_en_i,
    input  logic              data_i,
    output logic [NUM_CH-1:0] data_o,
    output logic [NUM_CH-1:0] prog_en_o,
    input  logic [NUM_CH-1:0] ccff_i,
    output logic              ccff_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              crc_err_o,
    output logic              cfg_err_o
);

    localparam int unsigned CH_W    = ch_width(NUM_CH);
    localparam int unsigned HDR_W   = CNT_W + LEN_W + CH_W;
    localparam int unsigned LEN_OFF = len_off(CNT_W);
    localparam int unsigned CH_OFF  = ch_off(CNT_W, LEN_W);
    localparam int unsigned BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int unsigned SUB_W   = $clog2((HDR_W > CRC_W) ? HDR_W : CRC_W);

    state_e            state_q, state_d;
    logic              crc_mode_q, crc_mode_d;
    logic              crc_err_q, crc_err_d;
    logic              cfg_err_q, cfg_err_d;
    logic [HDR_W-2:0]  hdr_q, hdr_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [CNT_W-1:0]  frame_q, frame_d, n_q, n_d;
    logic [LEN_W-1:0]  l_q, l_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] data_q, prog_q, prog_d;

    logic [HDR_W-1:0]  hdr_full;
    logic [CNT_W-1:0]  hdr_n;
    logic [LEN_W-1:0]  hdr_l, l_eff;
    logic [CH_W-1:0]   hdr_c;
    logic              last_frame, bit_last, res_zero;

    assign hdr_full   = {data_i, hdr_q};
    assign hdr_n      = hdr_full[CntOff +: CNT_W];
    assign hdr_l      = hdr_full[LEN_OFF +: LEN_W];
    assign hdr_c      = hdr_full[CH_OFF +: CH_W];
    assign l_eff      = (hdr_l == '0 || 32'(hdr_l) > FRAME_W) ? LEN_W'(FRAME_W) : hdr_l;
    assign last_frame = (frame_q == n_q - CNT_W'(1));
    assign bit_last   = (bit_q == BIT_W'(FRAME_W - 1));

    crc_serial #(
        .CRC_W   (CRC_W),
        .CRC_POLY(CRC_POLY)
    ) u_crc (
        .clk_i         (tck_i),
        .rst_ni        (rst_i),
        .clr_i         (state_q == StData && bit_q == '0),
        .en_i          (state_q == StData || state_q == StChk),
        .bit_i         (data_i),
        .residue_zero_o(res_zero)
    );

    always_comb begin
        state_d    = state_q;
        crc_mode_d = crc_mode_q;
        crc_err_d  = crc_err_q;
        cfg_err_d  = cfg_err_q;
        hdr_d      = hdr_q;
        sub_d      = sub_q;
        bit_d      = bit_q;
        frame_d    = frame_q;
        n_d        = n_q;
        l_d        = l_q;
        ch_d       = ch_q;
        prog_d     = '0;

        unique case (state_q)
            StIdle: begin
                if (en_i) begin
                    state_d    = StHdr;
                    crc_mode_d = crc_en_i;
                    crc_err_d  = 1'b0;
                    cfg_err_d  = 1'b0;
                    sub_d      = '0;
                end
            end
            StHdr: begin
                hdr_d = hdr_full[HDR_W-1:1];
                sub_d = sub_q + SUB_W'(1);
                if (sub_q == SUB_W'(HDR_W - 1)) begin
                    sub_d   = '0;
                    bit_d   = '0;
                    frame_d = '0;
                    if (32'(hdr_c) >= NUM_CH) begin
                        state_d   = StErr;
                        cfg_err_d = 1'b1;
                    end else begin
                        ch_d    = hdr_c;
                        n_d     = hdr_n;
                        l_d     = l_eff;
                        state_d = (hdr_n == '0) ? StDone : StData;
                    end
                end
            end
            StData: begin
                if (!last_frame || LEN_W'(bit_q) < l_q) prog_d = NUM_CH'(1) << ch_q;
                bit_d = bit_q + BIT_W'(1);
                if (bit_last) begin
                    bit_d = '0;
                    if (crc_mode_q) begin
                        state_d = StChk;
                        sub_d   = '0;
                    end else if (last_frame) begin
                        state_d = StDone;
                    end else begin
                        frame_d = frame_q + CNT_W'(1);
                    end
                end
            end
            StChk: begin
                sub_d = sub_q + SUB_W'(1);
                if (sub_q == SUB_W'(CRC_W - 1)) begin
                    sub_d = '0;
                    if (!res_zero) begin
                        state_d   = StErr;
                        crc_err_d = 1'b1;
                    end else if (last_frame) begin
                        state_d = StDone;
                    end else begin
                        state_d = StData;
                        frame_d = frame_q + CNT_W'(1);
                    end
                end
            end
            StDone, StErr: ;
            default: state_d = StIdle;
        endcase

        // Abort wins over everything decided above, and never raises a flag.
        if (state_q != StIdle && !en_i) begin
            state_d   = StIdle;
            prog_d    = '0;
            crc_err_d = crc_err_q;
            cfg_err_d = cfg_err_q;
        end
    end

    always_ff @(posedge tck_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            crc_mode_q <= 1'b0;
            crc_err_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
            hdr_q      <= '0;
            sub_q      <= '0;
            bit_q      <= '0;
            frame_q    <= '0;
            n_q        <= '0;
            l_q        <= '0;
            ch_q       <= '0;
            data_q     <= '0;
            prog_q     <= '0;
        end else begin
            state_q    <= state_d;
            crc_mode_q <= crc_mode_d;
            crc_err_q  <= crc_err_d;
            cfg_err_q  <= cfg_err_d;
            hdr_q      <= hdr_d;
            sub_q      <= sub_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            n_q        <= n_d;
            l_q        <= l_d;
            ch_q       <= ch_d;
            data_q     <= {NUM_CH{data_i}};
            prog_q     <= prog_d;
        end
    end

    always_comb begin
        ccff_o = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) ccff_o = ccff_i[k];
        end
    end

    assign data_o    = data_q;
    assign prog_en_o = prog_q;
    assign busy_o    = (state_q == StHdr) || (state_q == StData) || (state_q == StChk);
    assign done_o    = (state_q == StDone);
    assign crc_err_o = crc_err_q;
    assign cfg_err_o = cfg_err_q;

endmodule
